// File: rtl/btn_intr_arbiter_pkg.sv
// btn_arb_pkg: shared state encoding and default sizing for the button interrupt arbiter.
package btn_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_WAIT_ACK, ST_RELEASE} state_t;
  localparam int N_BTN_DEF = 4;
  localparam logic [7:0] ACK_TIMEOUT_DEF = 8'hFF;
endpackage

// File: rtl/btn_intr_arbiter_rr_picker.sv
// rr_picker: round-robin search of the request vector starting just above last_grant.
module rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         valid
);
  logic [W-1:0] idx;
  // Scan from the farthest candidate down so the nearest one after last wins.
  always_comb begin
    winner = '0;
    idx = '0;
    valid = |req;
    for (int i = N; i >= 1; i--) begin
      idx = W'((int'(last) + i) % N);
      if (req[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/btn_intr_arbiter.sv
// btn_intr_arbiter: edge-detects debounced button pulses and serialises them to a CPU interrupt handshake.
// Define BTN_ARB_TIMEOUT_EN to abandon events the CPU does not acknowledge within ACK_TIMEOUT clocks.
module btn_intr_arbiter
  import btn_arb_pkg::*;
#(
  parameter int          N_BTN       = N_BTN_DEF,
  parameter logic [7:0]  ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  localparam int         W           = $clog2(N_BTN)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] BTN_PULSE,
  input  logic             INTR_ACK,
  input  logic             CLR_ERR,
  output logic             INTR,
  output logic [W-1:0]     EVENT_ID,
  output logic [N_BTN-1:0] OVF,
  output logic             TIMEOUT
);
  state_t state_q, state_d;
  logic [N_BTN-1:0] prev_q, pending_q, pending_d, ovf_q, ovf_d, evt, clr;
  logic [W-1:0] last_q, last_d, id_q, id_d, winner;
  logic valid, grant, to_hit;

  rr_picker #(.N(N_BTN), .W(W)) u_pick (
    .req(pending_q),
    .last(last_q),
    .winner(winner),
    .valid(valid)
  );

  always_ff @(posedge CLK or posedge RST)
    if (RST) state_q <= ST_IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:     state_d = |pending_q ? ST_GRANT : ST_IDLE;
      ST_GRANT:    state_d = valid ? ST_WAIT_ACK : ST_IDLE;
      ST_WAIT_ACK: state_d = INTR_ACK ? ST_RELEASE : to_hit ? ST_IDLE : ST_WAIT_ACK;
      ST_RELEASE:  state_d = INTR_ACK ? ST_RELEASE : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb INTR = state_q == ST_WAIT_ACK;

  // A new event on the bit being granted re-arms it rather than overflowing.
  always_comb begin
    evt = BTN_PULSE & ~prev_q;
    grant = state_q == ST_GRANT && valid;
    clr = grant ? N_BTN'(1) << winner : '0;
    pending_d = (pending_q & ~clr) | evt;
    ovf_d = (CLR_ERR ? '0 : ovf_q) | (evt & pending_q & ~clr);
    last_d = grant ? winner : last_q;
    id_d = grant ? winner : id_q;
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      prev_q <= '0;
      pending_q <= '0;
      ovf_q <= '0;
      last_q <= W'(N_BTN - 1);
      id_q <= '0;
    end else begin
      prev_q <= BTN_PULSE;
      pending_q <= pending_d;
      ovf_q <= ovf_d;
      last_q <= last_d;
      id_q <= id_d;
    end

  assign EVENT_ID = id_q;
  assign OVF = ovf_q;

`ifdef BTN_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
  always_comb begin
    cnt_d = state_q == ST_WAIT_ACK ? cnt_q + 8'd1 : '0;
    to_hit = state_q == ST_WAIT_ACK && !INTR_ACK && cnt_q == ACK_TIMEOUT;
    timeout_d = (CLR_ERR ? 1'b0 : timeout_q) | to_hit;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  assign TIMEOUT = timeout_q;
`else
  logic unused_ack_timeout;
  assign unused_ack_timeout = ^ACK_TIMEOUT;
  assign to_hit = 1'b0;
  assign TIMEOUT = 1'b0;
`endif
endmodule

// File: tb/tb_btn_intr_arbiter.sv
// tb_btn_intr_arbiter: table-driven and directed checks of the button interrupt arbiter.
module tb_btn_intr_arbiter;
  logic clk = 1'b0, rst = 1'b1, ack = 1'b0, clr = 1'b0, intr, tout;
  logic [3:0] btn = '0, ovf;
  logic [1:0] id;
  int checks = 0, errors = 0;
  typedef struct {
    logic r;
    logic [3:0] b;
    logic a, c, intr;
    logic [1:0] id;
    logic [3:0] ovf;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  btn_intr_arbiter #(.N_BTN(4), .ACK_TIMEOUT(8'h10)) dut (
    .CLK(clk), .RST(rst), .BTN_PULSE(btn), .INTR_ACK(ack), .CLR_ERR(clr),
    .INTR(intr), .EVENT_ID(id), .OVF(ovf), .TIMEOUT(tout)
  );

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic v(input logic r, input logic [3:0] b, input logic a, input logic c,
                   input logic i, input logic [1:0] d, input logic [3:0] o);
    tbl.push_back('{r, b, a, c, i, d, o});
  endtask

  task automatic cyc(input logic [3:0] b, input logic a, input logic c);
    @(negedge clk);
    btn = b; ack = a; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_intr(input logic [1:0] exp_id, input string n);
    for (int k = 0; k < 8 && intr !== 1'b1; k++) cyc(4'b0, 1'b0, 1'b0);
    check({n, "_intr"}, 32'(intr), 32'd1);
    check({n, "_id"}, 32'(id), 32'(exp_id));
  endtask

  task automatic ack_it(input string n);
    cyc(4'b0, 1'b1, 1'b0);
    check({n, "_rel"}, 32'(intr), 32'd0);
    cyc(4'b0, 1'b0, 1'b0);
  endtask

  task automatic count_intr(input int cycles, input string n);
    int cnt;
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      cyc(4'b0, 1'b0, 1'b0);
      if (intr) cnt++;
    end
    check(n, 32'(cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // single 3-clk pulse on button 2
    v(0,4'h4,0,0, 0,0,0); v(0,4'h4,0,0, 0,0,0); v(0,4'h4,0,0, 1,2,0); v(0,4'h0,0,0, 1,2,0);
    v(0,4'h0,1,0, 0,2,0); v(0,4'h0,0,0, 0,2,0); v(0,4'h0,0,0, 0,2,0); v(0,4'h0,0,0, 0,2,0);
    v(1,4'h0,0,0, 0,0,0);
    // buttons 0,1,3 together, served 0,1,3
    v(0,4'hB,0,0, 0,0,0); v(0,4'h0,0,0, 0,0,0); v(0,4'h0,0,0, 1,0,0); v(0,4'h0,1,0, 0,0,0);
    v(0,4'h0,0,0, 0,0,0); v(0,4'h0,0,0, 0,0,0); v(0,4'h0,0,0, 1,1,0); v(0,4'h0,1,0, 0,1,0);
    v(0,4'h0,0,0, 0,1,0); v(0,4'h0,0,0, 0,1,0); v(0,4'h0,0,0, 1,3,0); v(0,4'h0,1,0, 0,3,0);
    v(0,4'h0,0,0, 0,3,0);
    // repeat pulses on button 1: pending, overflow beating clear, then clear
    v(0,4'h2,0,0, 0,3,0); v(0,4'h0,0,0, 0,3,0); v(0,4'h0,0,0, 1,1,0); v(0,4'h2,0,0, 1,1,0);
    v(0,4'h0,0,0, 1,1,0); v(0,4'h2,0,1, 1,1,2); v(0,4'h0,0,1, 1,1,0); v(0,4'h0,1,0, 0,1,0);
    v(0,4'h0,0,0, 0,1,0); v(0,4'h0,0,0, 0,1,0);
    // event on button 1 at the same edge its grant clears it: stays pending, no overflow
    v(0,4'h2,0,0, 1,1,0); v(0,4'h0,1,0, 0,1,0); v(0,4'h0,0,0, 0,1,0); v(0,4'h0,0,0, 0,1,0);
    v(0,4'h0,0,0, 1,1,0); v(0,4'h0,1,0, 0,1,0); v(0,4'h0,0,0, 0,1,0);

    #3;
    check("reset_intr", 32'(intr), 32'd0);
    check("reset_id", 32'(id), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_timeout", 32'(tout), 32'd0);
    @(negedge clk) rst = 1'b0;

    foreach (tbl[i]) begin
      rst = tbl[i].r;
      cyc(tbl[i].b, tbl[i].a, tbl[i].c);
      check($sformatf("row%0d_intr", i), 32'(intr), 32'(tbl[i].intr));
      check($sformatf("row%0d_id", i), 32'(id), 32'(tbl[i].id));
      check($sformatf("row%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
      check($sformatf("row%0d_timeout", i), 32'(tout), 32'd0);
    end

    // last grant 1: serve 0 alone, then 0+1 together comes out as 1 then 0
    cyc(4'h1, 1'b0, 1'b0);
    wait_intr(2'd0, "rr_a");
    ack_it("rr_a");
    cyc(4'h3, 1'b0, 1'b0);
    wait_intr(2'd1, "rr_b");
    ack_it("rr_b");
    wait_intr(2'd0, "rr_c");
    ack_it("rr_c");

    // ack held high across two pending events acknowledges only one
    cyc(4'h5, 1'b0, 1'b0);
    wait_intr(2'd2, "hold");
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(4'h0, 1'b1, 1'b0);
      if (intr) n++;
    end
    check("hold_count", 32'(n), 32'd0);
    check("hold_id", 32'(id), 32'd2);
    cyc(4'h0, 1'b0, 1'b0);
    wait_intr(2'd0, "hold2");
    ack_it("hold2");

    // asynchronous reset mid-handshake with 1010 pending
    cyc(4'h4, 1'b0, 1'b0);
    wait_intr(2'd2, "arst");
    cyc(4'hA, 1'b0, 1'b0);
    cyc(4'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_intr", 32'(intr), 32'd0);
    check("arst_id", 32'(id), 32'd0);
    @(negedge clk) rst = 1'b0;
    count_intr(10, "arst_pending");

    // pulse held high through reset release counts once
    @(negedge clk);
    rst = 1'b1;
    btn = 4'h4;
    @(negedge clk) rst = 1'b0;
    wait_intr(2'd2, "held");
    ack_it("held");
    count_intr(8, "held_once");

    cyc(4'h1, 1'b0, 1'b0);
    wait_intr(2'd0, "to");
`ifdef BTN_ARB_TIMEOUT_EN
    n = 1;
    for (int k = 0; k < 40; k++) begin
      cyc(4'h0, 1'b0, 1'b0);
      if (!intr) break;
      n++;
    end
    check("to_cycles", 32'(n), 32'd17);
    check("to_flag", 32'(tout), 32'd1);
    cyc(4'h0, 1'b0, 1'b1);
    check("to_clr", 32'(tout), 32'd0);
    cyc(4'h1, 1'b0, 1'b0);
    wait_intr(2'd0, "lim");
    repeat (16) cyc(4'h0, 1'b0, 1'b0);
    check("lim_intr_before", 32'(intr), 32'd1);
    cyc(4'h0, 1'b1, 1'b0);
    check("lim_intr", 32'(intr), 32'd0);
    check("lim_flag", 32'(tout), 32'd0);
    cyc(4'h0, 1'b0, 1'b0);
`else
    repeat (40) cyc(4'h0, 1'b0, 1'b0);
    check("noto_intr", 32'(intr), 32'd1);
    check("noto_flag", 32'(tout), 32'd0);
    ack_it("noto");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
